mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch (IF) requester and the data-memory (DM) requester of the pipeline.
- Arbitrates between them and drives the select of the 2:1 address/data mux in front of the memory.
- Sequences fixed-latency accesses and returns a one-cycle ready pulse plus read data to the winner.
- Sits between the IF/MEM stages and the memory model; the hazard unit stalls the pipeline on not-ready.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory access latency in cycles; legal values are 1 and above
STARVE_MAX, 3, number of consecutive DM grants with IF pending after which IF is forced

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  ADDR_W  fetch address
if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ready
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_ready  out  1  one-cycle pulse: data access complete
dm_rdata  out  DATA_W  load data
mem_en  out  1  memory access active
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  muxed address
mem_wdata  out  DATA_W  dm_wdata (passed through)
mem_rdata  in  DATA_W  memory read data, valid in the final ACCESS cycle
addr_sel  out  1  mux select: 0 = IF, 1 = DM
busy  out  1  high when state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state:
  - state = IDLE; grant = 0; lat_cnt = 0; starve_cnt = 0; rdata_q = 0.
  - All outputs are 0.
- Reset mid-access: the access is aborted immediately. mem_en and mem_we drop, and no ready pulse is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE arbitration, evaluated each cycle:
  - If dm_req and (starve_cnt < STARVE_MAX or !if_req): grant DM.
  - Else if if_req: grant IF.
  - Else stay in IDLE.
  - On any grant: register grant, load lat_cnt = MEM_LAT-1, go to ACCESS.
- starve_cnt update at each grant:
  - Increments when DM is granted while if_req is high, saturating at STARVE_MAX.
  - Clears when IF is granted, or when DM is granted with if_req low.
- ACCESS:
  - mem_en = 1 and addr_sel = grant.
  - mem_we = dm_we when grant = DM, else 0.
  - Decrement lat_cnt each cycle.
  - When lat_cnt == 0, capture mem_rdata into rdata_q and go to DONE.
  - Stay in ACCESS for exactly MEM_LAT cycles.
- DONE:
  - mem_en = 0 and mem_we = 0.
  - Pulse the granted requester's ready for one cycle.
  - Always return to IDLE. The requester drops req on the ready edge, so there is no re-grant from DONE.
- Latency: a request sampled in IDLE at cycle 0 produces ready in cycle MEM_LAT+1. The minimum issue-to-issue spacing is MEM_LAT+2 cycles.
- Data outputs:
  - if_rdata = dm_rdata = rdata_q.
  - On stores, dm_rdata is don't-care; the captured value is still loaded.
- Muxing:
  - mem_addr = addr_sel ? dm_addr : if_addr.
  - In IDLE, addr_sel = 0.
  - addr_sel holds constant through ACCESS and DONE.
- Withdrawn request: if req drops mid-access, the access still completes and the ready pulse is still issued. Sequencing is unaffected.
- Simultaneous requests in IDLE: DM wins, subject to the starvation rule.
- Ready pulses: both ready outputs are never high in the same cycle.

Decomposition:
- Shared header mem_arb_defs.vh:
  - State encodings ST_IDLE, ST_ACCESS, ST_DONE.
  - Grant encodings GNT_IF = 0, GNT_DM = 1.
- Sub-module: the address select instantiates the existing datapath Mux2x1 (size = ADDR_W, a = if_addr, b = dm_addr, sel = addr_sel).
- FSM, latency counter and starvation counter stay in this module.

Test Plan:
All scenarios use MEM_LAT=2, STARVE_MAX=3.
1. Reset: hold rst_n=0 with random inputs -> all outputs 0, busy 0. Assert rst_n low asynchronously mid-ACCESS -> mem_en 0 immediately and no ready. A request issued after release takes the full 3 cycles.
2. Fetch: if_req=1, if_addr=0x100 at cycle 0, memory returns 0x00000013 -> mem_en high cycles 1-2 with mem_addr=0x100 and addr_sel=0. if_ready pulses in cycle 3 with if_rdata=0x13. dm_ready stays 0.
3. Conflict: if_req with 0x104 and a load dm_req with 0x2000 both at cycle 0 -> DM served first (addr_sel=1, dm_ready cycle 3, dm_rdata = memory word at 0x2000). IF is then granted in cycle 4 and if_ready pulses in cycle 7.
4. Store: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_en=1 for exactly 2 cycles with mem_addr=0x40 and mem_wdata=0xDEADBEEF. dm_ready pulses in cycle 3.
5. Starvation: dm_req re-asserted continuously with if_req held high -> grant order DM, DM, DM, IF, DM. starve_cnt clears after the IF grant.
6. Withdrawal: if_req dropped in cycle 1 of an access -> if_ready still pulses in cycle 3, FSM back in IDLE in cycle 4, busy 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
// Holds FSM state codes, grant codes and a counter-width helper.
// Imported by the arbiter top; the address mux is encoding-agnostic.
package mem_port_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Grant encodings; these double as the address mux select value
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/Mux2x1.sv
// Generic 2:1 datapath mux.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module Mux2x1 #(
  parameter int size = 32
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            sel,
  output logic [size-1:0] out
);

  assign out = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data memory.
// Latency: request sampled in IDLE -> MEM_LAT access cycles -> ready pulse (MEM_LAT+1).
// No queueing: the loser simply holds its request; the pipeline stalls until ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              addr_sel,
  output logic              busy
);

  localparam int LW = cnt_w(MEM_LAT - 1);
  localparam int SW = cnt_w(STARVE_MAX);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mux_addr;

  // Next-state: IDLE arbitration with starvation guard, fixed-latency access, one DONE cycle
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_req && ((starve_q < STARVE_LIM) || !if_req)) begin
          // DM wins unless IF has waited through STARVE_MAX back-to-back DM grants
          grant_d  = GNT_DM;
          state_d  = ST_ACCESS;
          lat_d    = LAT_INIT;
          starve_d = !if_req ? '0 :
                     (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
        end else if (if_req) begin
          grant_d  = GNT_IF;
          state_d  = ST_ACCESS;
          lat_d    = LAT_INIT;
          starve_d = '0;
        end
      end
      ST_ACCESS: begin
        if (lat_q == '0) begin
          rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_DONE: begin
        // Requester drops req on the ready edge, so never re-grant from here
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any access in flight without a ready pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= GNT_IF;
      lat_q    <= '0;
      starve_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign addr_sel = busy && (grant_q == GNT_DM);
  assign mem_en   = (state_q == ST_ACCESS);
  assign mem_we   = mem_en && (grant_q == GNT_DM) && dm_we;
  assign if_ready = (state_q == ST_DONE) && (grant_q == GNT_IF);
  assign dm_ready = (state_q == ST_DONE) && (grant_q == GNT_DM);
  assign if_rdata = rdata_q;
  assign dm_rdata = rdata_q;

  Mux2x1 #(.size(ADDR_W)) u_addr_mux (
    .a   (if_addr),
    .b   (dm_addr),
    .sel (addr_sel),
    .out (mux_addr)
  );

  // Address and store data are held at zero outside ACCESS so the memory bus is quiet
  // (and all outputs read zero while held in reset)
  assign mem_addr  = mem_en ? mux_addr : '0;
  assign mem_wdata = mem_en ? dm_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        addr_sel;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_sel(addr_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Tiny memory model: a few fixed words, everything else a known pattern
  always_comb begin
    case (mem_addr)
      32'h0000_0100: mem_rdata = 32'h0000_0013;
      32'h0000_0104: mem_rdata = 32'h0050_0093;
      32'h0000_2000: mem_rdata = 32'h0000_CAFE;
      default:       mem_rdata = mem_addr ^ 32'hA5A5_A5A5;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_ready"}, {31'd0, if_ready}, 32'd0);
    chk({tag, "_dm_ready"}, {31'd0, dm_ready}, 32'd0);
    chk({tag, "_mem_en"},   {31'd0, mem_en},   32'd0);
    chk({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
    chk({tag, "_addr_sel"}, {31'd0, addr_sel}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
    chk({tag, "_mem_addr"}, mem_addr,          32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,        32'd0);
    chk({tag, "_if_rdata"}, if_rdata,          32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata,          32'd0);
  endtask

  // Expected grant order under continuous contention: DM, DM, DM, IF, DM
  logic [4:0] exp_sel;

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // ---- 1. reset with random inputs: everything reads zero ----
    for (int i = 0; i < 3; i++) begin
      if_req   = 1'($urandom);
      if_addr  = $urandom;
      dm_req   = 1'($urandom);
      dm_we    = 1'($urandom);
      dm_addr  = $urandom;
      dm_wdata = $urandom;
      cyc();
      chk_all_zero("reset");
    end
    idle_inputs();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    // ---- 2. fetch 0x100 ----
    if_req = 1'b1; if_addr = 32'h100;          // cycle 0
    cyc();                                     // cycle 1
    chk("fetch_c1_mem_en",   {31'd0, mem_en},   32'd1);
    chk("fetch_c1_mem_addr", mem_addr,          32'h100);
    chk("fetch_c1_addr_sel", {31'd0, addr_sel}, 32'd0);
    chk("fetch_c1_if_ready", {31'd0, if_ready}, 32'd0);
    cyc();                                     // cycle 2
    chk("fetch_c2_mem_en",   {31'd0, mem_en},   32'd1);
    chk("fetch_c2_mem_addr", mem_addr,          32'h100);
    chk("fetch_c2_mem_we",   {31'd0, mem_we},   32'd0);
    cyc();                                     // cycle 3
    chk("fetch_c3_if_ready", {31'd0, if_ready}, 32'd1);
    chk("fetch_c3_if_rdata", if_rdata,          32'h13);
    chk("fetch_c3_dm_ready", {31'd0, dm_ready}, 32'd0);
    chk("fetch_c3_mem_en",   {31'd0, mem_en},   32'd0);
    if_req = 1'b0;
    cyc();                                     // cycle 4
    chk("fetch_c4_busy",     {31'd0, busy},     32'd0);
    chk("fetch_c4_if_ready", {31'd0, if_ready}, 32'd0);

    // ---- 3. conflict: DM load 0x2000 beats IF 0x104 ----
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;   // cycle 0
    cyc();                                             // cycle 1
    chk("conf_c1_addr_sel", {31'd0, addr_sel}, 32'd1);
    chk("conf_c1_mem_addr", mem_addr,          32'h2000);
    chk("conf_c1_mem_we",   {31'd0, mem_we},   32'd0);
    cyc();                                             // cycle 2
    chk("conf_c2_addr_sel", {31'd0, addr_sel}, 32'd1);
    cyc();                                             // cycle 3
    chk("conf_c3_dm_ready", {31'd0, dm_ready}, 32'd1);
    chk("conf_c3_if_ready", {31'd0, if_ready}, 32'd0);
    chk("conf_c3_dm_rdata", dm_rdata,          32'h0000_CAFE);
    chk("conf_c3_addr_sel", {31'd0, addr_sel}, 32'd1);
    dm_req = 1'b0;
    cyc();                                             // cycle 4: IF granted
    chk("conf_c4_busy",     {31'd0, busy},     32'd0);
    cyc();                                             // cycle 5
    chk("conf_c5_addr_sel", {31'd0, addr_sel}, 32'd0);
    chk("conf_c5_mem_addr", mem_addr,          32'h104);
    cyc();                                             // cycle 6
    chk("conf_c6_if_ready", {31'd0, if_ready}, 32'd0);
    cyc();                                             // cycle 7
    chk("conf_c7_if_ready", {31'd0, if_ready}, 32'd1);
    chk("conf_c7_dm_ready", {31'd0, dm_ready}, 32'd0);
    chk("conf_c7_if_rdata", if_rdata,          32'h0050_0093);
    if_req = 1'b0;
    cyc();                                             // cycle 8

    // ---- 4. store 0xDEADBEEF to 0x40 ----
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 2; c++) begin
      cyc();
      chk($sformatf("store_c%0d_mem_en", c),    {31'd0, mem_en}, 32'd1);
      chk($sformatf("store_c%0d_mem_we", c),    {31'd0, mem_we}, 32'd1);
      chk($sformatf("store_c%0d_mem_addr", c),  mem_addr,        32'h40);
      chk($sformatf("store_c%0d_mem_wdata", c), mem_wdata,       32'hDEAD_BEEF);
    end
    cyc();                                             // cycle 3
    chk("store_c3_dm_ready", {31'd0, dm_ready}, 32'd1);
    chk("store_c3_mem_we",   {31'd0, mem_we},   32'd0);
    chk("store_c3_mem_en",   {31'd0, mem_en},   32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    cyc();
    chk("store_c4_busy", {31'd0, busy}, 32'd0);

    // ---- 5. starvation: continuous DM with IF pending ----
    exp_sel = 5'b10111;                                // bit g = grant g (1 = DM)
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    for (int g = 0; g < 5; g++) begin
      cyc();                                           // access cycle 1
      chk($sformatf("starve_g%0d_addr_sel", g), {31'd0, addr_sel}, {31'd0, exp_sel[g]});
      cyc();                                           // access cycle 2
      cyc();                                           // DONE
      chk($sformatf("starve_g%0d_dm_ready", g), {31'd0, dm_ready}, {31'd0, exp_sel[g]});
      chk($sformatf("starve_g%0d_if_ready", g), {31'd0, if_ready}, {31'd0, ~exp_sel[g]});
      if (g == 4) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      cyc();                                           // IDLE
      chk($sformatf("starve_g%0d_idle_busy", g), {31'd0, busy}, 32'd0);
    end

    // ---- 6. withdrawal: IF drops req in access cycle 1 ----
    if_req = 1'b1; if_addr = 32'h100;
    cyc();                                             // cycle 1
    chk("wd_c1_mem_en", {31'd0, mem_en}, 32'd1);
    if_req = 1'b0;
    cyc();                                             // cycle 2
    chk("wd_c2_mem_en", {31'd0, mem_en}, 32'd1);
    cyc();                                             // cycle 3
    chk("wd_c3_if_ready", {31'd0, if_ready}, 32'd1);
    chk("wd_c3_if_rdata", if_rdata,          32'h13);
    cyc();                                             // cycle 4
    chk("wd_c4_busy",     {31'd0, busy},     32'd0);
    chk("wd_c4_if_ready", {31'd0, if_ready}, 32'd0);
    cyc();
    chk("wd_c5_busy",     {31'd0, busy},     32'd0);

    // ---- 1b. async reset in the middle of an access ----
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h1234_5678;
    cyc();                                             // access cycle 1
    chk("rst_mid_pre_mem_en", {31'd0, mem_en}, 32'd1);
    chk("rst_mid_pre_mem_we", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid_busy",   {31'd0, busy},   32'd0);
    for (int c = 0; c < 2; c++) begin
      cyc();
      chk($sformatf("rst_hold%0d_dm_ready", c), {31'd0, dm_ready}, 32'd0);
      chk($sformatf("rst_hold%0d_if_ready", c), {31'd0, if_ready}, 32'd0);
    end
    idle_inputs();
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;                  // cycle 0 after release
    cyc();                                             // cycle 1
    chk("rel_c1_mem_en",   {31'd0, mem_en},   32'd1);
    chk("rel_c1_dm_ready", {31'd0, dm_ready}, 32'd0);
    cyc();                                             // cycle 2
    chk("rel_c2_if_ready", {31'd0, if_ready}, 32'd0);
    cyc();                                             // cycle 3
    chk("rel_c3_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rel_c3_if_rdata", if_rdata,          32'h13);
    if_req = 1'b0;
    cyc();
    chk("rel_c4_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
